// File: rtl/digit_serial_subtractor.sv
// Multi-cycle subtractor d = a - b - bin, DIGIT bits per clock through a registered borrow.
// Optional DSUB_SAT_EN: clamp d to 0 on unsigned underflow (bout still reports 1).
module digit_serial_subtractor #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, res_reg;
  logic             borrow_reg;
  logic [KW-1:0]    k_reg;
  logic             accept, step, done;
  logic [DIGIT-1:0] a_dig, b_dig;
  logic [DIGIT:0]   dig_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (k_reg == K_LAST) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // One digit of the borrow chain; the extra top bit is the digit's borrow-out.
  assign a_dig   = a_reg[int'(k_reg)*DIGIT +: DIGIT];
  assign b_dig   = b_reg[int'(k_reg)*DIGIT +: DIGIT];
  assign dig_ext = {1'b0, a_dig} - {1'b0, b_dig} - (DIGIT+1)'(borrow_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg      <= '0;
      b_reg      <= '0;
      res_reg    <= '0;
      borrow_reg <= 1'b0;
      k_reg      <= '0;
    end else if (accept) begin
      a_reg      <= a;
      b_reg      <= b;
      res_reg    <= '0;
      borrow_reg <= bin;
      k_reg      <= '0;
    end else if (step) begin
      res_reg[int'(k_reg)*DIGIT +: DIGIT] <= dig_ext[DIGIT-1:0];
      borrow_reg <= dig_ext[DIGIT];
      k_reg      <= (k_reg == K_LAST) ? '0 : k_reg + 1'b1;
    end
  end

  assign done = (state == DONE);
  assign bout = done && borrow_reg;
  // Overflow always judged on the wrapped result, even when saturating.
  assign ovf  = done && (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (res_reg[WIDTH-1] != a_reg[WIDTH-1]);

`ifdef DSUB_SAT_EN
  assign d = (done && borrow_reg) ? '0 : res_reg;
`else
  assign d = res_reg;
`endif

  assign zero = done && (d == '0);

endmodule

// File: tb/tb_digit_serial_subtractor.sv
// Randomised and directed bench for digit_serial_subtractor at three geometries
// (8/8 N=1, 16/1 N=16, 32/8 N=4) against an arithmetic reference model.
module tb_digit_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        bin_in = 1'b0;
  logic [2:0]  iv = '0;
  logic [2:0]  orr = '0;
  wire  [2:0]  ir, ov, bo, of, zr;
  wire  [7:0]  d0;
  wire  [15:0] d1;
  wire  [31:0] d2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  digit_serial_subtractor #(.WIDTH(8), .DIGIT(8)) u_n1 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a_in[7:0]), .b(b_in[7:0]), .bin(bin_in),
    .out_valid(ov[0]), .out_ready(orr[0]), .d(d0),
    .bout(bo[0]), .ovf(of[0]), .zero(zr[0]));

  digit_serial_subtractor #(.WIDTH(16), .DIGIT(1)) u_n16 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a_in[15:0]), .b(b_in[15:0]), .bin(bin_in),
    .out_valid(ov[1]), .out_ready(orr[1]), .d(d1),
    .bout(bo[1]), .ovf(of[1]), .zero(zr[1]));

  digit_serial_subtractor #(.WIDTH(32), .DIGIT(8)) u_main (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(a_in), .b(b_in), .bin(bin_in),
    .out_valid(ov[2]), .out_ready(orr[2]), .d(d2),
    .bout(bo[2]), .ovf(of[2]), .zero(zr[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] get_d(input int idx);
    case (idx)
      0:       return {24'h0, d0};
      1:       return {16'h0, d1};
      default: return d2;
    endcase
  endfunction

  function automatic bit sat_enabled();
`ifdef DSUB_SAT_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // One full transaction on instance idx; hold = DONE cycles with out_ready low,
  // noise = drive in_valid/out_ready and scramble operands while busy.
  task automatic run_op(input int idx, input logic [31:0] av, input logic [31:0] bv,
                        input logic bi_v, input int hold, input bit noise);
    int          w, n, cnt, lat;
    logic [31:0] mask, raw, exp_d;
    logic [32:0] full;
    logic        exp_bout, exp_ovf;
    w = (idx == 0) ? 8 : (idx == 1) ? 16 : 32;
    n = (idx == 0) ? 1 : (idx == 1) ? 16 : 4;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);

    full     = {1'b0, av & mask} - {1'b0, bv & mask} - {32'h0, bi_v};
    raw      = full[31:0] & mask;
    exp_bout = full[32];
    exp_ovf  = (av[w-1] != bv[w-1]) && (raw[w-1] != av[w-1]);
    exp_d    = (sat_enabled() && exp_bout) ? 32'h0 : raw;

    cnt = 0;
    while (!ir[idx] && cnt < 10) begin
      @(posedge clk); #1; cnt++;
    end
    check("in_ready_idle", {31'h0, ir[idx]}, 32'h1);

    a_in = av; b_in = bv; bin_in = bi_v; iv[idx] = 1'b1;
    @(posedge clk); #1;
    iv[idx] = noise; orr[idx] = noise;
    a_in = $urandom; b_in = $urandom; bin_in = 1'($urandom);
    check("in_ready_busy", {31'h0, ir[idx]}, 32'h0);

    lat = 0;
    while (!ov[idx] && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    orr[idx] = 1'b0;
    check("latency", lat, n);
    check("d", get_d(idx), exp_d);
    check("bout", {31'h0, bo[idx]}, {31'h0, exp_bout});
    check("ovf", {31'h0, of[idx]}, {31'h0, exp_ovf});
    check("zero", {31'h0, zr[idx]}, {31'h0, exp_d == 32'h0});

    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", {31'h0, ov[idx]}, 32'h1);
      check("hold_d", get_d(idx), exp_d);
    end
    iv[idx] = 1'b0;

    orr[idx] = 1'b1;
    @(posedge clk); #1;
    orr[idx] = 1'b0;
    check("valid_drop", {31'h0, ov[idx]}, 32'h0);
    check("ready_back", {31'h0, ir[idx]}, 32'h1);
    $display("op inst=%0d a=%h b=%h bin=%0d d=%h bout=%0d ovf=%0d zero=%0d lat=%0d",
             idx, av & mask, bv & mask, bi_v, get_d(idx), bo[idx], of[idx], zr[idx], lat);
  endtask

  initial begin
    #1;
    check("rst_in_ready", {29'h0, ir}, 32'h0);
    check("rst_out_valid", {29'h0, ov}, 32'h0);
    check("rst_d", d2, 32'h0);
    check("rst_flags", {26'h0, bo, of}, 32'h0);
    check("rst_zero", {29'h0, zr}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_ready", {29'h0, ir}, 32'h7);

    run_op(2, 32'h0000_0100, 32'h0000_0001, 1'b0, 0, 1'b0);
    run_op(2, 32'h0000_0000, 32'h0000_0001, 1'b0, 0, 1'b0);
    run_op(2, 32'h0000_0000, 32'h0000_0000, 1'b1, 0, 1'b0);
    run_op(2, 32'h8000_0000, 32'h0000_0001, 1'b0, 0, 1'b0);
    run_op(2, 32'd5, 32'd3, 1'b1, 0, 1'b0);
    run_op(2, 32'd5, 32'd4, 1'b1, 0, 1'b0);
    run_op(2, 32'h1234_5678, 32'h0000_0078, 1'b0, 5, 1'b1);

    // Asynchronous reset while the main instance is at digit k = 2.
    a_in = 32'hFFFF_0000; b_in = 32'h0000_1111; bin_in = 1'b1; iv[2] = 1'b1;
    @(posedge clk); #1;
    iv[2] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("midrst_valid", {31'h0, ov[2]}, 32'h0);
    check("midrst_d", d2, 32'h0);
    check("midrst_flags", {29'h0, bo[2], of[2], zr[2]}, 32'h0);
    check("midrst_ready", {31'h0, ir[2]}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rel_ready", {31'h0, ir[2]}, 32'h1);
    repeat (6) begin
      @(posedge clk); #1;
      check("rel_no_valid", {31'h0, ov[2]}, 32'h0);
    end
    run_op(2, 32'd10, 32'd3, 1'b0, 0, 1'b0);

    for (int i = 0; i < 20; i++)
      run_op(2, $urandom, $urandom, 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    run_op(0, 32'h0, 32'hFF, 1'b1, 0, 1'b0);
    for (int i = 0; i < 12; i++)
      run_op(0, $urandom, $urandom, 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom));
    run_op(1, 32'h0, 32'h0, 1'b1, 0, 1'b0);
    for (int i = 0; i < 12; i++)
      run_op(1, $urandom, $urandom, 1'($urandom), int'($urandom_range(0, 2)), 1'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
